otter_io_hub: RTL

- Memory-mapped peripheral block on the OTTER SoC IO bus, downstream of the SoC memory/IO decode.
- Consumes iobus_addr/iobus_out/iobus_wr and returns iobus_in combinationally for the SoC's registered load path.
- Contains an LED register, a synchronized switch input, a down-counting timer and a button edge detector.
- Drives the level-sensitive intrpt input of the MCU.

---
 rtl/otter_io_hub_if.sv | 9 +
 rtl/otter_io_hub.sv | 91 +++++++++
 2 files changed

// File: rtl/otter_io_hub_if.sv
// otter_io_hub_if: OTTER IO bus between SoC (master) and the IO hub (slave)
interface otter_io_hub_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  modport master (output iobus_addr, iobus_out, iobus_wr, input iobus_in);
  modport slave (input iobus_addr, iobus_out, iobus_wr, output iobus_in);
endinterface

// File: rtl/otter_io_hub.sv
// otter_io_hub: LED/switch/timer/button peripheral on the OTTER IO bus
module otter_io_hub #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int LED_W = 16,
  parameter int SW_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  otter_io_hub_if.slave    bus,
  input  logic [SW_W-1:0]  switches,
  input  logic             button,
  output logic [LED_W-1:0] leds,
  output logic             intrpt
);
  typedef enum logic [2:0] {
    R_LEDS   = 3'd0,
    R_SW     = 3'd1,
    R_CTRL   = 3'd2,
    R_LOAD   = 3'd3,
    R_COUNT  = 3'd4,
    R_STATUS = 3'd5
  } reg_e;
  logic             hit;
  logic [2:0]       idx;
  logic [31:0]      wd;
  logic             wr_leds, wr_ctrl, wr_load, wr_stat;
  logic [LED_W-1:0] leds_q;
  logic [SW_W-1:0]  sw1_q, sw2_q;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [31:0]      load_q;
  logic [31:0]      count_q, count_d;
  logic             tp_q, tp_d, bp_q, bp_d;
  logic [2:0]       btn_q;
  logic             expire;
  logic [31:0]      rd;
  assign hit = bus.iobus_addr[31:5] == BASE_ADDR[31:5];
  assign idx = bus.iobus_addr[4:2];
  assign wd = bus.iobus_out;
  assign wr_leds = bus.iobus_wr && hit && idx == R_LEDS;
  assign wr_ctrl = bus.iobus_wr && hit && idx == R_CTRL;
  assign wr_load = bus.iobus_wr && hit && idx == R_LOAD;
  assign wr_stat = bus.iobus_wr && hit && idx == R_STATUS;
  // Software writes take priority over the timer's own update; hardware sets beat W1C.
  always_comb begin
    expire = ctrl_q[0] && count_q == '0;
    count_d = wr_load ? wd :
              !ctrl_q[0] ? count_q :
              count_q != '0 ? count_q - 32'd1 :
              ctrl_q[1] ? load_q : '0;
    ctrl_d = wr_ctrl ? wd[3:0] : (expire && !ctrl_q[1]) ? {ctrl_q[3:1], 1'b0} : ctrl_q;
    tp_d = expire | (tp_q & ~(wr_stat & wd[0]));
    bp_d = (btn_q[1] & ~btn_q[2]) | (bp_q & ~(wr_stat & wd[1]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_q  <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      tp_q    <= 1'b0;
      bp_q    <= 1'b0;
      btn_q   <= '0;
    end else begin
      if (wr_leds) leds_q <= wd[LED_W-1:0];
      if (wr_load) load_q <= wd;
      sw1_q   <= switches;
      sw2_q   <= sw1_q;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      tp_q    <= tp_d;
      bp_q    <= bp_d;
      btn_q   <= {btn_q[1:0], button};
    end
  end
  always_comb begin
    case (idx)
      R_LEDS:   rd = 32'(leds_q);
      R_SW:     rd = 32'(sw2_q);
      R_CTRL:   rd = {28'd0, ctrl_q};
      R_LOAD:   rd = load_q;
      R_COUNT:  rd = count_q;
      R_STATUS: rd = {30'd0, bp_q, tp_q};
      default:  rd = '0;
    endcase
  end
  assign bus.iobus_in = hit ? rd : '0;
  assign leds = leds_q;
  assign intrpt = (tp_q & ctrl_q[2]) | (bp_q & ctrl_q[3]);
endmodule
